online_digit_select: RTL and testbench

Digit-selection and residual-update stage of the online (MSD-first) multiplier. Sits directly downstream of the five-digit signed-digit parallel adder. Each cycle it consumes one adder result, selects the output product digit p in {-1,0,+1}, forms the next residue 2(V - p) and registers it in plus/minus form. That residue feeds back into the adder's residue inputs. The block also sequences the online delay and digit count, and handshakes with the digit source and sink.

---
 rtl/online_digit_select_if.sv | 31 +++
 rtl/online_digit_select.sv | 117 +++++++++++
 tb/tb_online_digit_select.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/online_digit_select_if.sv
// Handshake and data bundle between the signed-digit adder, the digit-select
// stage and the product-digit sink.
interface online_digit_select_if #(
  parameter int BITS = 5
);
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] results_plus;
  logic [BITS-1:0] results_minus;
  logic [1:0]      cout;
  logic [BITS-1:0] residue_plus;
  logic [BITS-1:0] residue_minus;
  logic            p_plus;
  logic            p_minus;
  logic            out_valid;
  logic            done;
  logic            ovf;

  modport master (
    output start, in_valid, results_plus, results_minus, cout,
    input  in_ready, residue_plus, residue_minus, p_plus, p_minus,
           out_valid, done, ovf
  );

  modport slave (
    input  start, in_valid, results_plus, results_minus, cout,
    output in_ready, residue_plus, residue_minus, p_plus, p_minus,
           out_valid, done, ovf
  );
endinterface

// File: rtl/online_digit_select.sv
// Online multiplier digit selection + residue update (R = 2(V - p)), sequenced
// over DELAY + DIGITS steps. Define DIGIT_SEL_OVF_EN to enable the sticky ovf flag.
module online_digit_select #(
  parameter int BITS   = 5,
  parameter int DIGITS = 8,
  parameter int DELAY  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  online_digit_select_if.slave bus
);
  localparam int W     = BITS + 3;
  localparam int STEPS = DELAY + DIGITS;
  localparam int JW    = $clog2(STEPS + 1);
  localparam logic signed [W-1:0] ONE = W'(2 ** (BITS - 1));
  localparam logic signed [W-1:0] QTR = W'(2 ** (BITS - 2));

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [JW-1:0]   j;
  logic            accept, emit, last;
  logic signed [W-1:0] v, w, r, r_neg;
  logic            sel_pos, sel_neg;
  logic [BITS-1:0] r_plus, r_minus;

  logic [BITS-1:0] res_plus_q, res_minus_q;
  logic            p_plus_q, p_minus_q, out_valid_q, done_q;

  assign accept = (state == RUN) && bus.in_valid;
  assign emit   = (j >= JW'(DELAY));
  assign last   = (j == JW'(STEPS - 1));

  // V is exact in W bits: |V| <= 2^(BITS+1) - 1 and |R| stays below 2^(W-1).
  always_comb begin
    v = W'(bus.results_plus) - W'(bus.results_minus)
      + (W'(bus.cout[1]) << BITS) - (W'(bus.cout[0]) << BITS);
    sel_pos = emit && (v >= QTR);
    sel_neg = emit && (v < -QTR);
    w = v;
    if (sel_pos)      w = v - ONE;
    else if (sel_neg) w = v + ONE;
    r       = w <<< 1;
    r_neg   = -r;
    r_plus  = '0;
    r_minus = '0;
    if (r[W-1]) r_minus = r_neg[BITS-1:0];
    else        r_plus  = r[BITS-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = INIT;
      INIT:    state_nxt = RUN;
      RUN:     if (accept && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      j           <= '0;
      res_plus_q  <= '0;
      res_minus_q <= '0;
      p_plus_q    <= 1'b0;
      p_minus_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= accept && emit;
      done_q      <= (state == DONE);
      if (state == INIT) begin
        j           <= '0;
        res_plus_q  <= '0;
        res_minus_q <= '0;
        p_plus_q    <= 1'b0;
        p_minus_q   <= 1'b0;
      end else if (accept) begin
        j           <= j + 1'b1;
        res_plus_q  <= r_plus;
        res_minus_q <= r_minus;
        p_plus_q    <= sel_pos;
        p_minus_q   <= sel_neg;
      end
    end
  end

`ifdef DIGIT_SEL_OVF_EN
  localparam logic signed [W-1:0] RMAX = W'(2 ** BITS - 1);
  logic r_ovf, ovf_q;

  assign r_ovf = (r > RMAX) || (r < -RMAX);

  // Sticky across the operation; a fresh start clears it.
  always_ff @(posedge clk) begin
    if (rst)                          ovf_q <= 1'b0;
    else if (state == IDLE && bus.start) ovf_q <= 1'b0;
    else if (accept && r_ovf)         ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready      = (state == RUN);
  assign bus.residue_plus  = res_plus_q;
  assign bus.residue_minus = res_minus_q;
  assign bus.p_plus        = p_plus_q;
  assign bus.p_minus       = p_minus_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_online_digit_select.sv
// Bench for online_digit_select: directed and randomized operations checked
// against an integer-arithmetic model of the digit-selection rules.
module tb_online_digit_select;
  localparam int BITS   = 5;
  localparam int DIGITS = 8;
  localparam int DELAY  = 2;
  localparam int STEPS  = DELAY + DIGITS;
  localparam int ONE    = 1 << (BITS - 1);
  localparam int RMAX   = (1 << BITS) - 1;
`ifdef DIGIT_SEL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  online_digit_select_if #(.BITS(BITS)) bus ();

  online_digit_select #(.BITS(BITS), .DIGITS(DIGITS), .DELAY(DELAY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  function automatic int val_of(input logic [BITS-1:0] pl, input logic [BITS-1:0] mi,
                                input logic [1:0] c);
    int s;
    s = (int'(c[1]) - int'(c[0])) * (1 << BITS);
    for (int i = 0; i < BITS; i++) s += (int'(pl[i]) - int'(mi[i])) * (1 << i);
    return s;
  endfunction

  function automatic int pick(input int v, input bit emitting);
    if (!emitting)      return 0;
    if (v >= ONE / 2)   return 1;
    if (v < -(ONE / 2)) return -1;
    return 0;
  endfunction

  function automatic logic [BITS-1:0] enc_plus(input int r);
    return (r >= 0) ? BITS'(r % (1 << BITS)) : '0;
  endfunction

  function automatic logic [BITS-1:0] enc_minus(input int r);
    return (r < 0) ? BITS'((-r) % (1 << BITS)) : '0;
  endfunction

  function automatic logic [1:0] pbits(input int p);
    return (p > 0) ? 2'b10 : (p < 0) ? 2'b01 : 2'b00;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic vld, input logic [BITS-1:0] pl,
                        input logic [BITS-1:0] mi, input logic [1:0] c);
    bus.in_valid      = vld;
    bus.results_plus  = pl;
    bus.results_minus = mi;
    bus.cout          = c;
  endtask

  task automatic begin_op;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b1;
    set_in(1'b1, BITS'($urandom), BITS'($urandom), 2'($urandom));
    tick();
    set_in(1'b1, BITS'($urandom), BITS'($urandom), 2'($urandom));
    tick();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset.in_ready got %b want 0", bus.in_ready); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid got %b want 0", bus.out_valid); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset.done got %b want 0", bus.done); end
    n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset.ovf got %b want 0", bus.ovf); end
    n_chk++; if (bus.residue_plus !== '0) begin n_fail++; $display("FAIL reset.residue_plus got %b want 0", bus.residue_plus); end
    n_chk++; if (bus.residue_minus !== '0) begin n_fail++; $display("FAIL reset.residue_minus got %b want 0", bus.residue_minus); end
    n_chk++; if ({bus.p_plus, bus.p_minus} !== 2'b00) begin n_fail++; $display("FAIL reset.p got %b want 00", {bus.p_plus, bus.p_minus}); end
    rst       = 1'b0;
    bus.start = 1'b0;
    set_in(1'b0, '0, '0, 2'b00);
    tick();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset.idle_hold got %b want 0", bus.in_ready); end
  endtask

  task automatic test_zero;
    int ndig = 0;
    begin_op();
    for (int k = 0; k < STEPS; k++) begin
      set_in(1'b1, '0, '0, 2'b00);
      tick();
      n_chk++; if (bus.out_valid !== (k >= DELAY)) begin n_fail++; $display("FAIL zero.out_valid step %0d got %b want %b", k, bus.out_valid, k >= DELAY); end
      n_chk++; if ({bus.p_plus, bus.p_minus} !== 2'b00) begin n_fail++; $display("FAIL zero.p step %0d got %b want 00", k, {bus.p_plus, bus.p_minus}); end
      n_chk++; if ({bus.residue_plus, bus.residue_minus} !== '0) begin n_fail++; $display("FAIL zero.residue step %0d got %b/%b want 0/0", k, bus.residue_plus, bus.residue_minus); end
      if (bus.out_valid === 1'b1) ndig++;
    end
    set_in(1'b0, '0, '0, 2'b00);
    n_chk++; if (ndig != DIGITS) begin n_fail++; $display("FAIL zero.digits got %0d want %0d", ndig, DIGITS); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero.done_early got %b want 0", bus.done); end
    tick();
    n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero.done got %b want 1", bus.done); end
    tick();
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero.done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_select;
    logic [BITS-1:0] tp [STEPS];
    logic [BITS-1:0] tm [STEPS];
    logic [1:0]      tc [STEPS];
    int v, p, r;
    for (int k = 0; k < STEPS; k++) begin tp[k] = '0; tm[k] = '0; tc[k] = 2'b00; end
    tp[0] = 5'b00011;                                // delay step, V = 3
    tm[1] = 5'b00111;                                // delay step, V = -7
    tp[2] = 5'b01100;                                // V = 12
    tm[3] = 5'b01001;                                // V = -9
    tp[4] = 5'b01000;                                // V = 8
    tm[5] = 5'b01000;                                // V = -8
    tm[6] = 5'b11111; tc[6] = 2'b10;                 // V = 1
    tp[7] = 5'b00111; tm[7] = 5'b00001;              // V = 6
    tm[8] = 5'b11111; tc[8] = 2'b01;                 // V = -63
    tp[9] = 5'b11111; tc[9] = 2'b10;                 // V = 63
    begin_op();
    for (int k = 0; k < STEPS; k++) begin
      v = val_of(tp[k], tm[k], tc[k]);
      p = pick(v, k >= DELAY);
      r = 2 * (v - p * ONE);
      set_in(1'b1, tp[k], tm[k], tc[k]);
      tick();
      n_chk++; if (bus.out_valid !== (k >= DELAY)) begin n_fail++; $display("FAIL select.out_valid step %0d got %b want %b", k, bus.out_valid, k >= DELAY); end
      n_chk++; if ({bus.p_plus, bus.p_minus} !== pbits(p)) begin n_fail++; $display("FAIL select.p step %0d V=%0d got %b want %b", k, v, {bus.p_plus, bus.p_minus}, pbits(p)); end
      n_chk++; if (bus.residue_plus !== enc_plus(r)) begin n_fail++; $display("FAIL select.residue_plus step %0d V=%0d got %b want %b", k, v, bus.residue_plus, enc_plus(r)); end
      n_chk++; if (bus.residue_minus !== enc_minus(r)) begin n_fail++; $display("FAIL select.residue_minus step %0d V=%0d got %b want %b", k, v, bus.residue_minus, enc_minus(r)); end
    end
    set_in(1'b0, '0, '0, 2'b00);
    tick();
    n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL select.done got %b want 1", bus.done); end
    tick();
  endtask

  // Random operations; gap_pct > 0 inserts in_valid = 0 stalls inside RUN.
  // Each new op starts in the cycle done is visible (back-to-back).
  task automatic test_random(input int n_ops, input int gap_pct, input string tag);
    logic [BITS-1:0] pl, mi, exp_rp, exp_rm;
    logic [1:0]      c, exp_p;
    logic            vld, exp_ovf;
    int v, p, r, k, cycles, ndig;
    for (int op = 0; op < n_ops; op++) begin
      bus.start = 1'b1;
      set_in(1'($urandom), BITS'($urandom), BITS'($urandom), 2'($urandom));
      tick();
      bus.start = 1'b0;
      set_in(1'($urandom), BITS'($urandom), BITS'($urandom), 2'($urandom));
      n_chk++; if (bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL %s.init op %0d got ready=%b done=%b want 0/0", tag, op, bus.in_ready, bus.done); end
      n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL %s.ovf_clear op %0d got %b want 0", tag, op, bus.ovf); end
      tick();
      n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL %s.ready op %0d got %b want 1", tag, op, bus.in_ready); end
      exp_rp = '0; exp_rm = '0; exp_p = 2'b00; exp_ovf = 1'b0;
      k = 0; cycles = 0; ndig = 0;
      while (k < STEPS && cycles < 200) begin
        vld = ($urandom_range(99) >= gap_pct);
        pl  = BITS'($urandom); mi = BITS'($urandom); c = 2'($urandom);
        set_in(vld, pl, mi, c);
        tick();
        cycles++;
        if (vld) begin
          v = val_of(pl, mi, c);
          p = pick(v, k >= DELAY);
          r = 2 * (v - p * ONE);
          exp_rp = enc_plus(r); exp_rm = enc_minus(r); exp_p = pbits(p);
          if (OVF_EN && (r > RMAX || r < -RMAX)) exp_ovf = 1'b1;
        end
        n_chk++; if (bus.out_valid !== (vld && k >= DELAY)) begin n_fail++; $display("FAIL %s.out_valid op %0d step %0d got %b want %b", tag, op, k, bus.out_valid, vld && k >= DELAY); end
        n_chk++; if ({bus.p_plus, bus.p_minus} !== exp_p) begin n_fail++; $display("FAIL %s.p op %0d step %0d got %b want %b", tag, op, k, {bus.p_plus, bus.p_minus}, exp_p); end
        n_chk++; if (bus.residue_plus !== exp_rp || bus.residue_minus !== exp_rm) begin n_fail++; $display("FAIL %s.residue op %0d step %0d got %b/%b want %b/%b", tag, op, k, bus.residue_plus, bus.residue_minus, exp_rp, exp_rm); end
        n_chk++; if (bus.ovf !== exp_ovf) begin n_fail++; $display("FAIL %s.ovf op %0d step %0d got %b want %b", tag, op, k, bus.ovf, exp_ovf); end
        if (bus.out_valid === 1'b1) ndig++;
        if (vld) k++;
      end
      set_in(1'b0, '0, '0, 2'b00);
      n_chk++; if (k != STEPS) begin n_fail++; $display("FAIL %s.timeout op %0d accepted %0d want %0d", tag, op, k, STEPS); end
      n_chk++; if (ndig != DIGITS) begin n_fail++; $display("FAIL %s.digits op %0d got %0d want %0d", tag, op, ndig, DIGITS); end
      n_chk++; if (bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL %s.done_state op %0d got ready=%b done=%b want 0/0", tag, op, bus.in_ready, bus.done); end
      tick();
      n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL %s.done op %0d got %b want 1", tag, op, bus.done); end
      n_chk++; if (bus.ovf !== exp_ovf) begin n_fail++; $display("FAIL %s.ovf_sticky op %0d got %b want %b", tag, op, bus.ovf, exp_ovf); end
    end
    tick();
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s.done_pulse got %b want 0", tag, bus.done); end
  endtask

  task automatic test_ovf_reset;
    begin_op();
    set_in(1'b1, 5'b10100, '0, 2'b00);               // V = 20 in a delay step -> R = 40
    tick();
    n_chk++; if (bus.residue_plus !== 5'b01000 || bus.residue_minus !== '0) begin n_fail++; $display("FAIL ovf.residue got %b/%b want 01000/00000", bus.residue_plus, bus.residue_minus); end
    n_chk++; if (bus.ovf !== OVF_EN) begin n_fail++; $display("FAIL ovf.set got %b want %b", bus.ovf, OVF_EN); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf.delay_no_digit got %b want 0", bus.out_valid); end
    set_in(1'b1, '0, '0, 2'b00);
    tick();
    n_chk++; if (bus.ovf !== OVF_EN) begin n_fail++; $display("FAIL ovf.sticky got %b want %b", bus.ovf, OVF_EN); end
    set_in(1'b1, 5'b01100, '0, 2'b00);
    tick();
    rst = 1'b1;
    set_in(1'b1, BITS'($urandom), BITS'($urandom), 2'($urandom));
    tick();
    rst = 1'b0;
    set_in(1'b0, '0, '0, 2'b00);
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid.in_ready got %b want 0", bus.in_ready); end
    n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_mid.ovf got %b want 0", bus.ovf); end
    n_chk++; if ({bus.residue_plus, bus.residue_minus} !== '0) begin n_fail++; $display("FAIL rst_mid.residue got %b/%b want 0/0", bus.residue_plus, bus.residue_minus); end
    n_chk++; if ({bus.p_plus, bus.p_minus, bus.out_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_mid.p_valid got %b want 000", {bus.p_plus, bus.p_minus, bus.out_valid}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid.idle cycle %0d got done=%b ready=%b want 0/0", i, bus.done, bus.in_ready); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    set_in(1'b0, '0, '0, 2'b00);
    test_reset();
    test_zero();
    test_select();
    test_random(3, 30, "stall");
    test_random(4, 0, "back_to_back");
    test_ovf_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
